// File: rtl/lane_loader.sv
// Collects LANES lanes of LANE_W bits into one state block, then pulses start
// and holds the block stable until the encoder reports ready.
//
// state | meaning
// LOAD  | accepting lanes, in_ready=1
// START | one-cycle start pulse, block complete
// WAIT  | block held stable until ready
module lane_loader #(
  parameter int LANE_W = 64,
  parameter int LANES  = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [LANE_W-1:0]       in_lane,
  output logic                    in_ready,
  output logic [LANES*LANE_W-1:0] state_out,
  output logic                    start,
  input  logic                    ready,
  output logic                    busy,
  output logic [4:0]              lane_cnt
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_LANE = 5'(LANES - 1);

  state_t state, state_nxt;
  logic   xfer;
  logic   last_lane;

  assign xfer      = in_valid && (state == LOAD);
  assign last_lane = (lane_cnt == LAST_LANE);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (xfer && last_lane) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    case (state)
      LOAD:    in_ready = 1'b1;
      START: begin
        start = 1'b1;
        busy  = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Only LOAD writes, so the block is frozen from START through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt  <= 5'd0;
      state_out <= '0;
    end else if (xfer) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_cnt == 5'(i)) state_out[i*LANE_W +: LANE_W] <= in_lane;
      end
      lane_cnt <= last_lane ? 5'd0 : lane_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_lane_loader.sv
// Directed bench for lane_loader: a vector table for the basic block load,
// then hand-written sequences for gaps, held ready, resets and a second block.
module tb_lane_loader;

  localparam int LANE_W = 64;
  localparam int LANES  = 25;
  localparam int SW     = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [LANE_W-1:0] in_lane = '0;
  logic              in_ready;
  logic [SW-1:0]     state_out;
  logic              start;
  logic              ready = 1'b0;
  logic              busy;
  logic [4:0]        lane_cnt;

  int total = 0;
  int bad   = 0;

  lane_loader #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_lane   (in_lane),
    .in_ready  (in_ready),
    .state_out (state_out),
    .start     (start),
    .ready     (ready),
    .busy      (busy),
    .lane_cnt  (lane_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              vld;
    logic [LANE_W-1:0] lane;
    logic              rdy;
    logic              e_in_ready;
    logic              e_start;
    logic              e_busy;
    logic [4:0]        e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] mk_block(input logic [LANE_W-1:0] base);
    logic [SW-1:0] b;
    b = '0;
    for (int i = 0; i < LANES; i++) b[i*LANE_W +: LANE_W] = base + LANE_W'(i);
    return b;
  endfunction

  task automatic chk_state(input string nm, input logic [SW-1:0] exp);
    int first;
    total++;
    if (state_out !== exp) begin
      bad++;
      first = -1;
      for (int i = LANES - 1; i >= 0; i--)
        if (state_out[i*LANE_W +: LANE_W] !== exp[i*LANE_W +: LANE_W]) first = i;
      $display("FAIL %s: lane %0d got %0h expected %0h", nm, first,
               state_out[first*LANE_W +: LANE_W], exp[first*LANE_W +: LANE_W]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send_lanes(input logic [LANE_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_lane  = base + LANE_W'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   cnt_exp;
    int   starts;

    // table: reset, 25 back-to-back lanes, one WAIT cycle, release with ready
    v = '{rst:1'b1, vld:1'b1, lane:64'hFFFF, rdy:1'b1,
          e_in_ready:1'b1, e_start:1'b0, e_busy:1'b0, e_cnt:5'd0};
    tbl.push_back(v);
    for (int i = 0; i < LANES; i++) begin
      v = '{rst:1'b0, vld:1'b1, lane:64'h1000 + 64'(i), rdy:1'b0,
            e_in_ready:(i < LANES - 1), e_start:(i == LANES - 1),
            e_busy:(i == LANES - 1), e_cnt:5'((i + 1) % LANES)};
      tbl.push_back(v);
    end
    v = '{rst:1'b0, vld:1'b0, lane:64'h0, rdy:1'b0,
          e_in_ready:1'b0, e_start:1'b0, e_busy:1'b1, e_cnt:5'd0};
    tbl.push_back(v);
    v = '{rst:1'b0, vld:1'b0, lane:64'h0, rdy:1'b1,
          e_in_ready:1'b1, e_start:1'b0, e_busy:1'b0, e_cnt:5'd0};
    tbl.push_back(v);

    #2;
    foreach (tbl[k]) begin
      rst = tbl[k].rst; in_valid = tbl[k].vld; in_lane = tbl[k].lane; ready = tbl[k].rdy;
      step();
      chk($sformatf("tbl%0d in_ready", k), 64'(in_ready), 64'(tbl[k].e_in_ready));
      chk($sformatf("tbl%0d start", k),    64'(start),    64'(tbl[k].e_start));
      chk($sformatf("tbl%0d busy", k),     64'(busy),     64'(tbl[k].e_busy));
      chk($sformatf("tbl%0d lane_cnt", k), 64'(lane_cnt), 64'(tbl[k].e_cnt));
      if (k == 0) chk_state("reset state_out", '0);
    end
    chk_state("b2b block", mk_block(64'h1000));

    // gaps: in_valid toggles every other cycle
    do_reset();
    cnt_exp = 0; starts = 0;
    for (int k = 0; k < 2 * LANES; k++) begin
      in_valid = (k % 2 == 0);
      in_lane  = in_valid ? 64'h1000 + 64'(k / 2) : 64'hDEAD_0000;
      step();
      if (k % 2 == 0) cnt_exp = (cnt_exp + 1) % LANES;
      chk($sformatf("gap lane_cnt k%0d", k), 64'(lane_cnt), 64'(cnt_exp));
      if (start) starts++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (start) starts++;
    end
    chk("gap start pulses", 64'(starts), 64'd1);
    chk("gap busy in wait", 64'(busy), 64'd1);
    chk_state("gap block", mk_block(64'h1000));
    ready = 1'b1; step(); ready = 1'b0;
    chk("gap back to load", 64'(in_ready), 64'd1);

    // ready held high throughout; in_valid stays up after the block
    do_reset();
    ready = 1'b1;
    send_lanes(64'h1000, LANES);
    chk("rdy start", 64'(start), 64'd1);
    chk("rdy in_ready start", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_lane = 64'h7777;
    step();
    chk("rdy wait start", 64'(start), 64'd0);
    chk("rdy wait busy", 64'(busy), 64'd1);
    chk("rdy wait in_ready", 64'(in_ready), 64'd0);
    chk("rdy wait cnt", 64'(lane_cnt), 64'd0);
    in_valid = 1'b0;
    step();
    chk("rdy load in_ready", 64'(in_ready), 64'd1);
    chk("rdy load busy", 64'(busy), 64'd0);
    chk("rdy held not consumed", 64'(lane_cnt), 64'd0);
    chk_state("rdy block", mk_block(64'h1000));
    ready = 1'b0;

    // reset mid-load with a simultaneous transfer, then a fresh block
    do_reset();
    send_lanes(64'hBAD0, 10);
    chk("abort cnt before", 64'(lane_cnt), 64'd10);
    rst = 1'b1; in_valid = 1'b1; in_lane = 64'h5555; ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0; ready = 1'b0;
    chk("abort cnt", 64'(lane_cnt), 64'd0);
    chk_state("abort state_out", '0);
    starts = 0;
    for (int i = 0; i < LANES; i++) begin
      in_valid = 1'b1; in_lane = 64'h1000 + 64'(i);
      step();
      if (start) starts++;
    end
    in_valid = 1'b0;
    step();
    if (start) starts++;
    chk("abort new start once", 64'(starts), 64'd1);
    chk_state("abort new block", mk_block(64'h1000));

    // reset while in WAIT
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst wait busy", 64'(busy), 64'd0);
    chk("rst wait in_ready", 64'(in_ready), 64'd1);

    // reset on the edge of the 25th transfer suppresses start
    send_lanes(64'h3000, LANES - 1);
    rst = 1'b1; in_valid = 1'b1; in_lane = 64'h3018;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst last start", 64'(start), 64'd0);
    chk("rst last cnt", 64'(lane_cnt), 64'd0);
    step();
    chk("rst last no late start", 64'(start), 64'd0);

    // reset in START
    send_lanes(64'h3000, LANES);
    chk("rst start pre", 64'(start), 64'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst start start", 64'(start), 64'd0);
    chk("rst start busy", 64'(busy), 64'd0);
    chk_state("rst start cleared", '0);

    // two blocks; lane offered during WAIT is held and taken in LOAD
    do_reset();
    send_lanes(64'h1000, LANES);
    in_valid = 1'b1; in_lane = 64'h2000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("blk1 wait cnt %0d", k), 64'(lane_cnt), 64'd0);
    end
    chk_state("blk1 stable in wait", mk_block(64'h1000));
    ready = 1'b1; step(); ready = 1'b0;
    chk("blk2 load cnt", 64'(lane_cnt), 64'd0);
    send_lanes(64'h2000, LANES);
    chk("blk2 start", 64'(start), 64'd1);
    chk_state("blk2 block", mk_block(64'h2000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lane_loader.md
LANE_LOADER -- requirements
Module: lane_loader

Interface
REQ-001 Parameter LANE_W, default 64, width of one state lane.
REQ-002 Parameter LANES, default 25, lanes per state block (5x5).
REQ-003 clk  input  1  sole clock; all registers update on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream lane present on in_lane.
REQ-006 in_lane  input  LANE_W  lane data.
REQ-007 in_ready  output  1  loader can accept a lane this cycle.
REQ-008 state_out  output  LANES*LANE_W  assembled state block driven to encoder datapath.
REQ-009 start  output  1  one-cycle start pulse to encoder controller.
REQ-010 ready  input  1  encoder controller done flag.
REQ-011 busy  output  1  high from START through WAIT.
REQ-012 lane_cnt  output  5  lanes accepted in current block (0..LANES-1).

Function
REQ-013 FSM states: LOAD, START, WAIT; encoding free, exactly three states.
REQ-014 Lane transfer occurs on a rising edge where in_valid=1 and in_ready=1; no other edge accepts data.
REQ-015 in_ready SHALL be 1 only in LOAD; 0 in START and WAIT.
REQ-016 Accepted lane written to state_out[lane_cnt*LANE_W +: LANE_W]; lane index i = x + 5*y, lane 0 at LSBs.
REQ-017 Each transfer increments lane_cnt by 1; in_valid=0 cycles hold lane_cnt and state_out unchanged (gaps allowed, any length).
REQ-018 Transfer with lane_cnt = LANES-1: lane written, lane_cnt wraps to 0, next state START.
REQ-019 START lasts exactly one cycle: start=1, busy=1; next state WAIT unconditionally.
REQ-020 start SHALL be 0 in every cycle except START; never high two consecutive cycles.
REQ-021 WAIT: busy=1; on edge with ready=1 go to LOAD; else stay.
REQ-022 ready is ignored in LOAD and START (a ready already high in START does not skip WAIT; it is sampled at the first WAIT edge).
REQ-023 state_out SHALL be stable from the edge entering START until the edge leaving WAIT.
REQ-024 On return to LOAD state_out is not cleared; lanes are overwritten in order by the next block; latency first-lane-accepted to start = 25 transfers + 1 cycle.
REQ-025 in_lane/in_valid offered during START/WAIT are not consumed; upstream must hold them until in_ready=1.

Reset
REQ-026 rst=1 at an edge: state LOAD, lane_cnt=0, state_out=0, start=0, busy=0; in_ready=1 from the following cycle.
REQ-027 rst has priority over any simultaneous transfer or ready; applies identically mid-LOAD, in START, or in WAIT (partial block discarded, pending start suppressed).

Verification
REQ-028 Reset then 25 back-to-back lanes with value 64'h1000+i -> lane i at bits [64i+:64], start high exactly one cycle after the 25th transfer edge, in_ready=0, busy=1.
REQ-029 25 lanes with in_valid toggled every other cycle -> same state_out as REQ-028, lane_cnt advances only on valid cycles, start single pulse.
REQ-030 ready held at 1 throughout -> START still one cycle, WAIT exactly one cycle, in_ready=1 two cycles after the last transfer edge.
REQ-031 rst=1 after 10 lanes -> lane_cnt=0, state_out=0; then 25 new lanes -> start once, no lane from aborted block present.
REQ-032 Second block of 25 lanes (value 64'h2000+i) after ready -> state_out unchanged during WAIT of block 1, fully replaced by block 2 at its start pulse; in_valid held during WAIT not consumed.
